// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : fifo_uart_tx
// Brief   : Drains a byte FIFO onto an 8N1, LSB-first UART TX line.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_busy,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  tx_active,
  output logic                  tx_done
);

  localparam int                   c_IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_POP    = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt,   w_cnt_nxt;
  logic [c_IDX_W-1:0]    r_idx,   w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  w_bit_end;

  assign w_bit_end = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    fifo_pop    = 1'b0;
    tx          = 1'b1;
    tx_active   = 1'b0;
    tx_done     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!fifo_empty && !fifo_busy) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        // Re-check the flags: the producer may have started a push meanwhile.
        w_state_nxt = (fifo_empty || fifo_busy) ? S_IDLE : S_POP;
      end
      S_POP: begin
        fifo_pop    = 1'b1;
        w_shift_nxt = fifo_data;
        w_state_nxt = S_START;
      end
      S_START: begin
        tx        = 1'b0;
        tx_active = 1'b1;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        tx        = r_shift[r_idx];
        tx_active = 1'b1;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) begin
          if (r_idx == c_IDX_LAST) w_state_nxt = S_STOP;
          else                     w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_STOP: begin
        tx_active = 1'b1;
        tx_done   = w_bit_end;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// Bench for fifo_uart_tx: queue-based FIFO, frame-timeline reference model,
// per-cycle output comparison, and a UART receiver for byte-order checks.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_busy = 1'b0;
  logic       fifo_pop, tx, tx_active, tx_done;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .CNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_busy(fifo_busy), .fifo_pop(fifo_pop), .tx(tx), .tx_active(tx_active),
    .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO: the front advances half a cycle after the pop cycle has been sampled.
  logic [7:0] q[$];
  logic       pop_seen = 1'b0;
  int         n_pops = 0;

  always @(posedge clock) begin
    cyc++;
    pop_seen <= fifo_pop;
  end

  always @(negedge clock) begin
    if (pop_seen) begin
      n_pops++;
      check("pop_nonempty", (q.size() != 0), 1);
      if (q.size() != 0) void'(q.pop_front());
    end
    #1;
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() == 0) ? 8'h00 : q[0];
  end

  // Reference model: 0 = idle, 1 = settle, 2 = pop, 3 = in frame (m_t = cycle of frame).
  int         m_pre = 0;
  int         m_t   = 0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clock) begin
    if (reset) begin
      m_pre = 0; m_t = 0; m_byte = 8'h00;
    end else begin
      case (m_pre)
        0: if (!fifo_empty && !fifo_busy) m_pre = 1;
        1: m_pre = (!fifo_empty && !fifo_busy) ? 2 : 0;
        2: begin m_byte = fifo_data; m_t = 0; m_pre = 3; end
        default: if (m_t == FRAME - 1) begin m_pre = 0; m_t = 0; end else m_t++;
      endcase
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Per-cycle compare plus event logging and a simple receiver.
  int         n_done = 0;
  int         starts[$];
  int         dones[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_b = 8'h00;
  int         rx_j = 0;
  logic       prev_act = 1'b0;

  always @(negedge clock) begin
    logic e_act, e_pop, e_tx, e_done;
    e_act  = (m_pre == 3);
    e_pop  = (m_pre == 2);
    e_tx   = e_act ? frame_bit(m_byte, m_t / CPB) : 1'b1;
    e_done = e_act && (m_t == FRAME - 1);
    check("tx", tx, e_tx);
    check("tx_active", tx_active, e_act);
    check("fifo_pop", fifo_pop, e_pop);
    check("tx_done", tx_done, e_done);

    if (tx_active && !prev_act) starts.push_back(cyc);
    prev_act = tx_active;
    if (tx_done) begin n_done++; dones.push_back(cyc); end
    if (!tx_active) rx_j = 0;
    else begin
      if ((rx_j % CPB) == 2 && (rx_j / CPB) >= 1 && (rx_j / CPB) <= 8) rx_b[rx_j/CPB-1] = tx;
      if (tx_done) rx_q.push_back(rx_b);
      rx_j++;
    end
  end

  task automatic wait_pop(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (fifo_pop) begin at = cyc; break; end
    end
    check("pop_timeout", (at >= 0), 1);
  endtask

  task automatic wait_dones(input int target, input int limit);
    int i;
    for (i = 0; i < limit && n_done < target; i++) @(negedge clock);
    check("done_timeout", (n_done >= target), 1);
  endtask

  initial begin
    int         rel_cyc, pop_at, p0, d0;
    logic       frm[FRAME];
    logic [9:0] lit_a5;
    logic       all_high;

    // Reset with data already waiting.
    q.push_back(8'hA5);
    repeat (3) begin
      @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_pop", fifo_pop, 0);
      check("rst_active", tx_active, 0);
    end
    reset   = 1'b0;
    rel_cyc = cyc;

    // Single byte 0xA5.
    wait_pop(10, pop_at);
    check("a5_pop_latency", pop_at - rel_cyc, 2);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clock);
      frm[j] = tx;
      if (j == FRAME - 1) check("a5_done_at_40", tx_done, 1);
    end
    lit_a5 = 10'b1101001010;
    for (int k = 0; k < 10; k++) begin
      check("a5_bit", frm[4*k+2], lit_a5[k]);
      check("model_bit", frame_bit(8'hA5, k), lit_a5[k]);
    end
    repeat (2) @(negedge clock);
    check("a5_one_pop", n_pops, 1);
    check("a5_rx", rx_q[rx_q.size()-1], 8'hA5);

    // Three queued bytes, back to back.
    starts.delete(); dones.delete(); rx_q.delete();
    p0 = n_pops; d0 = n_done;
    q.push_back(8'h01); q.push_back(8'h80); q.push_back(8'hFF);
    wait_dones(d0 + 3, 300);
    repeat (3) @(negedge clock);
    check("b2b_pops", n_pops - p0, 3);
    check("b2b_fifo_empty", q.size(), 0);
    if (starts.size() >= 3 && dones.size() >= 3 && rx_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) check("b2b_len", dones[i] - starts[i], FRAME - 1);
      check("b2b_gap0", starts[1] - dones[0], 4);
      check("b2b_gap1", starts[2] - dones[1], 4);
      check("b2b_rx0", rx_q[0], 8'h01);
      check("b2b_rx1", rx_q[1], 8'h80);
      check("b2b_rx2", rx_q[2], 8'hFF);
    end else check("b2b_events", starts.size(), 3);

    // Producer busy blocks the pop; busy rising during SETTLE aborts it.
    p0 = n_pops; d0 = n_done;
    fifo_busy = 1'b1;
    q.push_back(8'h5A);
    repeat (20) @(negedge clock);
    check("busy_no_pop", n_pops - p0, 0);
    fifo_busy = 1'b0;
    @(negedge clock);
    fifo_busy = 1'b1;
    repeat (6) @(negedge clock);
    check("settle_abort_no_pop", n_pops - p0, 0);
    fifo_busy = 1'b0;
    wait_pop(10, pop_at);
    wait_dones(d0 + 1, 60);
    check("busy_rx", rx_q[rx_q.size()-1], 8'h5A);

    // Reset during DATA bit 3 drops that byte; the next one goes out intact.
    repeat (2) @(negedge clock);
    d0 = n_done;
    q.push_back(8'hC3); q.push_back(8'h96);
    wait_pop(10, pop_at);
    repeat (18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx", tx, 1);
    check("abort_active", tx_active, 0);
    reset = 1'b0;
    wait_dones(d0 + 1, 80);
    check("abort_one_done", n_done - d0, 1);
    check("abort_rx", rx_q[rx_q.size()-1], 8'h96);

    // Long empty stretch.
    repeat (2) @(negedge clock);
    check("idle_fifo_empty", q.size(), 0);
    p0 = n_pops; d0 = n_done; all_high = 1'b1;
    repeat (100) begin
      @(negedge clock);
      all_high = all_high & tx;
    end
    check("idle_tx_high", all_high, 1);
    check("idle_no_pop", n_pops - p0, 0);
    check("idle_no_done", n_done - d0, 0);

    // Randomised traffic, busy and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (($urandom % 8) == 0 && q.size() < 6) q.push_back(8'($urandom));
      fifo_busy = (($urandom % 5) == 0);
      reset     = (($urandom % 600) == 0);
    end
    reset = 1'b0; fifo_busy = 1'b0;
    for (int i = 0; i < 2000 && (q.size() != 0 || tx_active || !fifo_empty); i++) @(negedge clock);
    check("drain", (q.size() == 0 && !tx_active), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
